divide_unit: RTL and testbench
==============================

# divide_unit

Multicycle radix-2 restoring integer divider that serves the ALU's divide requests for MIPS32 DIV/DIVU. It accepts a single-cycle start pulse with operands and holds `Stall` high while iterating. It then presents a registered quotient and remainder, which the ALU commits to HI/LO on the first cycle `Stall` is low. It runs in the Execute stage beside the ALU and never stalls the pipeline itself; the ALU decides when to wait.

## Interface
- `WIDTH`, default 32: operand, quotient and remainder width.
- `clock`  input  1: rising-edge clock.
- `reset`  input  1: reset; asynchronous, active-low.
- `OP_div`  input  1: start a signed divide; sampled only in IDLE.
- `OP_divu`  input  1: start an unsigned divide; sampled only in IDLE.
- `Dividend`  input  WIDTH: numerator; captured on the start edge.
- `Divisor`  input  WIDTH: denominator; captured on the start edge.
- `Quotient`  output  WIDTH: registered quotient; valid when `Stall`=0 after an operation.
- `Remainder`  output  WIDTH: registered remainder; valid when `Stall`=0 after an operation.
- `Stall`  output  1: high while an operation is in progress.

## Operation
- States:
  - IDLE: `Stall`=0.
  - BUSY: `Stall`=1. It holds a 5-bit iteration counter plus negate-quotient and negate-remainder flags.
- IDLE → BUSY on a clock edge with `OP_div|OP_divu`:
  - Latch the absolute values of the operands (signed mode), or the raw operands (unsigned mode).
  - Set the negate-quotient flag to sign(Dividend)^sign(Divisor).
  - Set the negate-remainder flag to sign(Dividend).
  - Clear the partial remainder.
  - Set the counter to WIDTH-1.
- If both starts are high, `OP_div` wins.
- Starts while BUSY are ignored; operands are not re-captured.
- BUSY, each edge: shift {partial remainder, quotient} left by one bit. Trial-subtract the divisor over WIDTH+1 bits. If the result is non-negative, keep it and set quotient bit 0.
- On the edge where the counter reaches 0:
  - Write `Quotient` and `Remainder` with sign correction applied (two's-complement negate when the corresponding flag is set).
  - Return to IDLE.
- Signed semantics: the quotient truncates toward zero; the remainder takes the sign of the dividend.
- Signed 0x80000000 / 0xFFFFFFFF yields Q=0x80000000, R=0. No exception is raised.
- Divisor zero, both modes: Q=0xFFFFFFFF, R=Dividend (the original, uncorrected value). This is forced regardless of sign flags. No exception.
- `Quotient`/`Remainder` hold their last values in IDLE until the next completion.
- Reset asserted at any time, including mid-operation:
  - State goes to IDLE; `Stall`=0.
  - `Quotient` and `Remainder` are cleared to 0; the counter and flags are cleared.
  - No partial result is written.

## Timing
- Start edge E0: `Stall` rises after E0.
- Iterations run on E1..E32. Results are written on E32, and `Stall` falls after E32.
- `Stall` is high for exactly WIDTH cycles. Results are valid in the first cycle `Stall` is low.
- A new start is accepted on the first edge after `Stall` falls. Back-to-back operations therefore have a start-to-start spacing of WIDTH+1 cycles.
- No combinational path from inputs to outputs.

## Configuration
- `DIVIDE_FAST_ZERO_EN` defined:
  - A zero divisor on the start edge skips BUSY iterations.
  - The forced zero-divisor result is written on E1, and `Stall` is high for exactly 1 cycle.
- Not defined: a zero divisor runs the full WIDTH iterations (`Stall` high for WIDTH cycles); the final write is overridden with the same forced result.
- Results are identical in both configurations; only latency differs.

## Structure
- Shared package holds:
  - `DIV_WIDTH` (32).
  - `DIV_CNT_W` ($clog2(DIV_WIDTH)).
  - The divider state enum (IDLE, BUSY).
  - `DIV_ZERO_QUOTIENT` (all ones).
- One combinational sub-module, `div_step`: a single restoring iteration. It takes partial remainder, quotient and divisor in, and gives next partial remainder and quotient out. It is instantiated once and reused each cycle.
- Sign capture and sign correction stay in the top level.

## Test plan
- Unsigned 100 / 7 via `OP_divu` → `Stall` high 32 cycles, then Q=14, R=2.
- Signed 0xFFFFFFF9 (−7) / 2 via `OP_div` → Q=0xFFFFFFFD, R=0xFFFFFFFF. Also 7 / 0xFFFFFFFE (−2) → Q=0xFFFFFFFD, R=1.
- 0x80000000 / 0xFFFFFFFF: signed → Q=0x80000000, R=0; unsigned → Q=0, R=0x80000000.
- 0x12345678 / 0 in both modes → Q=0xFFFFFFFF, R=0x12345678. `Stall` width is 1 cycle with `DIVIDE_FAST_ZERO_EN`, 32 without.
- Start 1000/3, then pulse `OP_divu` with 5/5 mid-operation → the second start is ignored, result Q=333, R=1. Assert `reset` at iteration 10 of a new divide → `Stall`, Q and R are 0 immediately. After release, a fresh 9/3 gives Q=3, R=0.
- Start on the first cycle `Stall` is low after a completed op → accepted, and the previous result holds until the new completion.

Source files
------------

// File: rtl/divide_unit_pkg.sv
// Shared constants and state type for the multicycle restoring divider.
package divide_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } div_state_e;

endpackage

// File: rtl/divide_unit_div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the
// divisor, keep the difference and set the quotient bit when it is non-negative.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    logic        [W:0] shifted;
    logic signed [W:0] diff;

    // rem < divisor keeps the W+1-bit difference in signed range
    always_comb begin
        shifted = {rem_i, quo_i[W-1]};
        diff    = $signed(shifted) - $signed({1'b0, dvs_i});
        rem_o   = diff[W] ? shifted[W-1:0] : diff[W-1:0];
        quo_o   = {quo_i[W-2:0], ~diff[W]};
    end

endmodule

// File: rtl/divide_unit.sv
// MIPS32 DIV/DIVU multicycle divider: Stall is high while iterating, results
// are registered. Define DIVIDE_FAST_ZERO_EN to finish a zero-divisor op in 1 cycle.
module divide_unit
    import divide_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             OP_div,
    input  logic             OP_divu,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Stall
);

    div_state_e           state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                 negq_q, negq_d, negr_q, negr_d, zero_q, zero_d;
    logic [WIDTH-1:0]     rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
    logic [WIDTH-1:0]     quot_q, quot_d, remo_q, remo_d;
    logic [WIDTH-1:0]     rem_nx, quo_nx;
    logic                 dvd_neg, dvs_neg;

    function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
        return neg ? (~v + 1'b1) : v;
    endfunction

    div_step #(.W(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_nx),
        .quo_o (quo_nx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dvd_neg = OP_div & Dividend[WIDTH-1];
        dvs_neg = OP_div & Divisor[WIDTH-1];
        case (state_q)
            IDLE: begin
                if (OP_div | OP_divu) begin
                    state_d = BUSY;
                    quo_d   = cond_neg(dvd_neg, Dividend);
                    dvs_d   = cond_neg(dvs_neg, Divisor);
                    dvd_d   = Dividend;
                    rem_d   = '0;
                    negq_d  = dvd_neg ^ dvs_neg;
                    negr_d  = dvd_neg;
                    zero_d  = (Divisor == '0);
                    cnt_d   = DIV_CNT_W'(WIDTH - 1);
`ifdef DIVIDE_FAST_ZERO_EN
                    if (Divisor == '0) cnt_d = '0;
`endif
                end
            end
            BUSY: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    // zero divisor overrides sign correction with the raw dividend
                    if (zero_q) begin
                        quot_d = WIDTH'(DIV_ZERO_QUOTIENT);
                        remo_d = dvd_q;
                    end else begin
                        quot_d = cond_neg(negq_q, quo_nx);
                        remo_d = cond_neg(negr_q, rem_nx);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
        end
    end

    always_ff @(posedge clock) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
        dvd_q <= dvd_d;
    end

    assign Quotient  = quot_q;
    assign Remainder = remo_q;
    assign Stall     = (state_q == BUSY);

endmodule

// File: tb/tb_divide_unit.sv
// Self-checking bench for divide_unit: directed corner cases plus random
// DIV/DIVU operations against an arithmetic reference model.
module tb_divide_unit;

    localparam int WIDTH = 32;
`ifdef DIVIDE_FAST_ZERO_EN
    localparam int ZW = 1;
`else
    localparam int ZW = WIDTH;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             OP_div = 1'b0;
    logic             OP_divu = 1'b0;
    logic [WIDTH-1:0] Dividend = '0;
    logic [WIDTH-1:0] Divisor = '0;
    logic [WIDTH-1:0] Quotient, Remainder;
    logic             Stall;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] prev_q = '0;
    logic [31:0] prev_r = '0;

    divide_unit #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .OP_div    (OP_div),
        .OP_divu   (OP_divu),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Stall     (Stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'h0) return {32'hFFFF_FFFF, a};
        if (!sgn) return {a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    // Caller is at a negedge with Stall low; returns at the negedge where Stall fell.
    task automatic run_op(input string tag, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
        logic [63:0] exp;
        int cyc;
        exp      = ref_div(sgn, a, b);
        OP_div   = sgn;
        OP_divu  = ~sgn;
        Dividend = a;
        Divisor  = b;
        @(posedge clock);
        #1;
        OP_div  = 1'b0;
        OP_divu = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clock);
            if (!Stall) break;
            cyc++;
            if (cyc == 1) begin
                chk({tag, "_holdQ"}, Quotient, prev_q);
                chk({tag, "_holdR"}, Remainder, prev_r);
            end
            if (inject && cyc == 5) begin
                OP_divu  = 1'b1;
                Dividend = 32'd5;
                Divisor  = 32'd5;
            end else begin
                OP_divu = 1'b0;
            end
            if (cyc > 200) break;
        end
        chk({tag, "_stall"}, cyc, (b == 0) ? ZW : WIDTH);
        chk({tag, "_Q"}, Quotient, exp[63:32]);
        chk({tag, "_R"}, Remainder, exp[31:0]);
        prev_q = exp[63:32];
        prev_r = exp[31:0];
    endtask

    initial begin
        logic [31:0] a, b;
        bit sgn;
        int sel;
        repeat (2) @(negedge clock);
        chk("rst_stall", {31'b0, Stall}, 32'd0);
        chk("rst_Q", Quotient, 32'd0);
        chk("rst_R", Remainder, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        run_op("u100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("s_min_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("u_min_-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("s_div0", 1'b1, 32'h1234_5678, 32'd0, 1'b0);
        run_op("u_div0", 1'b0, 32'h1234_5678, 32'd0, 1'b0);
        run_op("s_negdiv0", 1'b1, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_op("ignored", 1'b0, 32'd1000, 32'd3, 1'b1);

        // reset in the middle of an operation
        OP_divu  = 1'b1;
        Dividend = 32'd1000;
        Divisor  = 32'd7;
        @(posedge clock);
        #1;
        OP_divu = 1'b0;
        repeat (10) @(negedge clock);
        chk("mid_busy", {31'b0, Stall}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_stall", {31'b0, Stall}, 32'd0);
        chk("mid_rst_Q", Quotient, 32'd0);
        chk("mid_rst_R", Remainder, 32'd0);
        prev_q = '0;
        prev_r = '0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_op("u9_3", 1'b0, 32'd9, 32'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            sgn = $urandom_range(0, 1);
            a   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2, 3: b = $urandom_range(1, 300);
                4: b = -$urandom_range(1, 300);
                default: b = $urandom;
            endcase
            if (sel == 1 && i % 2 == 0) a = 32'h8000_0000;
            run_op("rand", sgn, a, b, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
